// File: rtl/iic_arbiter_if.sv
// Requester-side and IIC-driver-side bundles for iic_arbiter.
// master drives the command (requesters / arbiter); slave answers it (arbiter / driver).
interface iic_req_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_rd;
    logic [15:0] req_dev;
    logic [31:0] req_reg;
    logic [15:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  req_done;
    logic [1:0]  req_err;
    logic [7:0]  rdata;
    logic        grant;

    modport master (
        output req_valid, req_rd, req_dev, req_reg, req_wdata,
        input  req_ready, req_done, req_err, rdata, grant
    );
    modport slave (
        input  req_valid, req_rd, req_dev, req_reg, req_wdata,
        output req_ready, req_done, req_err, rdata, grant
    );
endinterface

interface iic_drv_if;
    logic        start_en;
    logic        wr_rd_flag;
    logic [7:0]  i2c_device_addr;
    logic [15:0] register;
    logic [7:0]  data_byte;
    logic        busy;
    logic        err;
    logic [7:0]  rd_data;

    modport master (
        output start_en, wr_rd_flag, i2c_device_addr, register, data_byte,
        input  busy, err, rd_data
    );
    modport slave (
        input  start_en, wr_rd_flag, i2c_device_addr, register, data_byte,
        output busy, err, rd_data
    );
endinterface

// File: rtl/iic_arbiter.sv
// Two-requester round-robin arbiter in front of one IIC driver; IIC_ARB_TIMEOUT_EN adds a transaction watchdog.
// Latency: start_en the cycle after accept, req_done one cycle after the driver drops busy.
// Backpressure: req_ready only in IDLE with the driver idle; one transaction in flight at a time.
module iic_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input logic       clk_i,
    input logic       rst_n,
    iic_req_if.slave  req,
    iic_drv_if.master drv
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] WAIT_BUSY = 3'd2;
    localparam logic [2:0] RUN       = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;

    typedef struct packed {
        logic        rd;
        logic [7:0]  dev;
        logic [15:0] regad;
        logic [7:0]  wdata;
    } cmd_t;

    logic [2:0] state;
    logic       last_grant;
    logic       grant_q;
    logic       start_q;
    logic       err_acc;
    logic [1:0] done_q;
    logic [1:0] err_q;
    logic [7:0] rdata_q;
    cmd_t       cmd_q;

    logic       win;
    logic [1:0] ready;
    logic       accept;
    cmd_t       win_cmd;

    // With both requesters pending the one that did not go last wins.
    always_comb begin
        win   = (req.req_valid == 2'b11) ? ~last_grant : req.req_valid[1];
        ready = 2'b00;
        if (state == IDLE && !drv.busy && req.req_valid != 2'b00) begin
            ready[win] = 1'b1;
        end
        win_cmd.rd = req.req_rd[win];
        if (win) begin
            win_cmd.dev   = req.req_dev[15:8];
            win_cmd.regad = req.req_reg[31:16];
            win_cmd.wdata = req.req_wdata[15:8];
        end else begin
            win_cmd.dev   = req.req_dev[7:0];
            win_cmd.regad = req.req_reg[15:0];
            win_cmd.wdata = req.req_wdata[7:0];
        end
    end

    assign accept = |(req.req_valid & ready);

`ifdef IIC_ARB_TIMEOUT_EN
    // Accept and START precede counting and DONE follows the hit, hence the offset of 3.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 3);
    logic [15:0] tmo_cnt;
    logic        tmo_hit;

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if (state == WAIT_BUSY || state == RUN) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    assign tmo_hit = (state == WAIT_BUSY || state == RUN) && (tmo_cnt == TMO_LAST);
`else
    logic tmo_hit;
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
            start_q    <= 1'b0;
            err_acc    <= 1'b0;
            done_q     <= 2'b00;
            err_q      <= 2'b00;
            rdata_q    <= 8'h00;
            cmd_q      <= '0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 2'b00;
            err_q   <= 2'b00;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cmd_q   <= win_cmd;
                        grant_q <= win;
                        start_q <= 1'b1;
                        state   <= START;
                    end
                end
                START: state <= WAIT_BUSY;
                WAIT_BUSY: begin
                    if (tmo_hit) begin
                        done_q[grant_q] <= 1'b1;
                        err_q[grant_q]  <= 1'b1;
                        rdata_q         <= 8'h00;
                        state           <= DONE;
                    end else if (drv.busy) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    err_acc <= err_acc | drv.err;
                    if (tmo_hit) begin
                        done_q[grant_q] <= 1'b1;
                        err_q[grant_q]  <= 1'b1;
                        rdata_q         <= 8'h00;
                        state           <= DONE;
                    end else if (!drv.busy) begin
                        done_q[grant_q] <= 1'b1;
                        err_q[grant_q]  <= err_acc | drv.err;
                        rdata_q         <= drv.rd_data;
                        state           <= DONE;
                    end
                end
                DONE: begin
                    last_grant <= grant_q;
                    err_acc    <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req.req_ready       = ready;
    assign req.req_done        = done_q;
    assign req.req_err         = err_q;
    assign req.rdata           = rdata_q;
    assign req.grant           = grant_q;
    assign drv.start_en        = start_q;
    assign drv.wr_rd_flag      = cmd_q.rd;
    assign drv.i2c_device_addr = cmd_q.dev;
    assign drv.register        = cmd_q.regad;
    assign drv.data_byte       = cmd_q.wdata;

endmodule

// File: tb/tb_iic_arbiter.sv
// Directed bench for iic_arbiter: behavioural IIC driver plus command/completion scoreboard.
module tb_iic_arbiter;

`ifdef IIC_ARB_TIMEOUT_EN
    localparam int unsigned TB_TMO = 20;
    localparam int          WR_BUSY = 10;
`else
    localparam int unsigned TB_TMO = 50000;
    localparam int          WR_BUSY = 100;
`endif

    typedef struct packed {
        logic        idx;
        logic        rd;
        logic [7:0]  dev;
        logic [15:0] regad;
        logic [7:0]  wd;
    } cmd_t;

    typedef struct packed {
        logic [1:0] done;
        logic [1:0] err;
        logic [7:0] rdata;
    } done_t;

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk_i = ~clk_i;

    iic_req_if req ();
    iic_drv_if drv ();

    iic_arbiter #(.TIMEOUT_CYCLES(TB_TMO)) dut (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .req   (req),
        .drv   (drv)
    );

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    int cyc = 0;
    int done_cyc = 0;
    int acc_cyc = 0;
    int drv_len = 4;
    int drv_err_at = -1;
    logic [7:0] drv_rdata = 8'h00;
    bit drv_on = 1'b1;

    cmd_t  exp_cmd[$];
    done_t exp_done[$];
    cmd_t  mon_c;
    done_t mon_d;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Behavioural driver: busy for drv_len cycles after start_en, optional one-cycle err pulse.
    always begin
        @(negedge clk_i);
        if (drv.start_en === 1'b1 && drv_on) begin
            drv.busy = 1'b1;
            for (int i = 0; i < drv_len; i++) begin
                @(negedge clk_i);
                drv.err = (i == drv_err_at);
            end
            drv.rd_data = drv_rdata;
            drv.busy    = 1'b0;
            drv.err     = 1'b0;
        end
    end

    always @(negedge clk_i) begin
        if (drv.start_en === 1'b1) begin
            start_cnt++;
            if (exp_cmd.size() == 0) begin
                check("start_unexpected", drv.start_en, 0);
            end else begin
                mon_c = exp_cmd.pop_front();
                check("grant", req.grant, mon_c.idx);
                check("cmd", {drv.wr_rd_flag, drv.i2c_device_addr, drv.register, drv.data_byte},
                      {mon_c.rd, mon_c.dev, mon_c.regad, mon_c.wd});
            end
        end
        if (req.req_done !== 2'b00) begin
            done_cnt++;
            done_cyc = cyc;
            if (exp_done.size() == 0) begin
                check("done_unexpected", req.req_done, 0);
            end else begin
                mon_d = exp_done.pop_front();
                check("req_done", req.req_done, mon_d.done);
                check("req_err", req.req_err, mon_d.err);
                check("rdata", req.rdata, mon_d.rdata);
            end
        end
    end

    task automatic issue(input logic [1:0] v, input logic [1:0] exp_rdy, input string tag);
        int n;
        req.req_valid = v;
        #1;
        n = 0;
        while (!(|(req.req_valid & req.req_ready)) && n < 200) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        check({tag, "_ready"}, req.req_ready, exp_rdy);
        acc_cyc = cyc;
        @(negedge clk_i);
        check({tag, "_start"}, drv.start_en, 1);
        req.req_valid = 2'b00;
        @(negedge clk_i);
        check({tag, "_start_1cyc"}, drv.start_en, 0);
    endtask

    task automatic wait_done(input int target, input string tag);
        for (int i = 0; i < 400 && done_cnt < target; i++) begin
            @(negedge clk_i);
            #1;
        end
        check(tag, done_cnt, target);
    endtask

    task automatic wait_start(input int target, input string tag);
        for (int i = 0; i < 400 && start_cnt < target; i++) begin
            @(negedge clk_i);
            #1;
        end
        check(tag, start_cnt, target);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_n = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        req.req_valid = 2'b00;
        req.req_rd    = 2'b00;
        req.req_dev   = 16'h0000;
        req.req_reg   = 32'h0;
        req.req_wdata = 16'h0000;
        drv.busy      = 1'b0;
        drv.err       = 1'b0;
        drv.rd_data   = 8'h00;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_outs", {drv.start_en, req.req_done, req.req_err, req.rdata, req.grant,
                           drv.wr_rd_flag, drv.i2c_device_addr, drv.register, drv.data_byte}, 0);
        rst_n = 1'b1;
        @(negedge clk_i);
        check("rst_ready_idle", req.req_ready, 2'b00);

        // Single write from requester 0.
        drv_len = WR_BUSY; drv_err_at = -1; drv_rdata = 8'hC3;
        req.req_rd = 2'b00; req.req_dev = 16'h0078; req.req_reg = 32'h0000_3008; req.req_wdata = 16'h0082;
        exp_cmd.push_back('{1'b0, 1'b0, 8'h78, 16'h3008, 8'h82});
        exp_done.push_back('{2'b01, 2'b00, 8'hC3});
        issue(2'b01, 2'b01, "wr");
        wait_done(1, "wr_done_cnt");

        // Requester 0 alone again: wins despite having gone last.
        drv_len = 5; drv_rdata = 8'h3C;
        req.req_rd = 2'b01; req.req_dev = 16'h0055; req.req_reg = 32'h0000_0101; req.req_wdata = 16'h00AA;
        exp_cmd.push_back('{1'b0, 1'b1, 8'h55, 16'h0101, 8'hAA});
        exp_done.push_back('{2'b01, 2'b00, 8'h3C});
        issue(2'b01, 2'b01, "solo0");
        wait_done(2, "solo0_done_cnt");

        // Read from requester 1 with an err pulse mid-RUN.
        drv_len = 12; drv_err_at = 8; drv_rdata = 8'hA5;
        req.req_rd = 2'b10; req.req_dev = 16'h5000; req.req_reg = 32'h1234_0000; req.req_wdata = 16'h0000;
        exp_cmd.push_back('{1'b1, 1'b1, 8'h50, 16'h1234, 8'h00});
        exp_done.push_back('{2'b10, 2'b10, 8'hA5});
        issue(2'b10, 2'b10, "rd1");
        wait_done(3, "rd1_done_cnt");

        // Contention straight after reset: 0,1,0,1.
        do_reset();
        drv_len = 4; drv_err_at = -1; drv_rdata = 8'h77;
        req.req_rd = 2'b10; req.req_dev = 16'h2211; req.req_reg = 32'h2222_1111; req.req_wdata = 16'h0201;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) exp_cmd.push_back('{1'b0, 1'b0, 8'h11, 16'h1111, 8'h01});
            else            exp_cmd.push_back('{1'b1, 1'b1, 8'h22, 16'h2222, 8'h02});
            exp_done.push_back((k % 2 == 0) ? done_t'{2'b01, 2'b00, 8'h77} : done_t'{2'b10, 2'b00, 8'h77});
        end
        req.req_valid = 2'b11;
        #1;
        check("rr_first_ready", req.req_ready, 2'b01);
        wait_start(7, "rr_start_cnt");
        req.req_valid = 2'b00;
        wait_done(7, "rr_done_cnt");

        // Reset during RUN abandons the transaction.
        drv_len = 30;
        req.req_rd = 2'b00; req.req_dev = 16'h0078; req.req_reg = 32'h0000_3008; req.req_wdata = 16'h0082;
        exp_cmd.push_back('{1'b0, 1'b0, 8'h78, 16'h3008, 8'h82});
        issue(2'b01, 2'b01, "abort");
        repeat (10) @(negedge clk_i);
        rst_n = 1'b0;
        @(negedge clk_i);
        rst_n = 1'b1;
        check("rst_mid_outs", {drv.start_en, req.req_done, req.req_err, req.rdata, req.grant, drv.wr_rd_flag,
                               drv.i2c_device_addr, drv.register, drv.data_byte, req.req_ready}, 0);

        // Driver still busy from the abandoned transfer: no ready until it finishes.
        drv_len = 6; drv_rdata = 8'h5A;
        req.req_rd = 2'b10; req.req_dev = 16'h2200; req.req_reg = 32'h2222_0000; req.req_wdata = 16'h0200;
        exp_cmd.push_back('{1'b1, 1'b1, 8'h22, 16'h2222, 8'h02});
        exp_done.push_back('{2'b10, 2'b00, 8'h5A});
        req.req_valid = 2'b10;
        #1;
        check("ready_while_busy", req.req_ready, 2'b00);
        @(negedge clk_i);
        issue(2'b10, 2'b10, "post_rst");
        wait_done(8, "post_rst_done_cnt");

`ifdef IIC_ARB_TIMEOUT_EN
        drv_on = 1'b0;
        req.req_rd = 2'b00; req.req_dev = 16'h0033; req.req_reg = 32'h0000_4444; req.req_wdata = 16'h0066;
        exp_cmd.push_back('{1'b0, 1'b0, 8'h33, 16'h4444, 8'h66});
        exp_done.push_back('{2'b01, 2'b01, 8'h00});
        issue(2'b01, 2'b01, "tmo");
        wait_done(9, "tmo_done_cnt");
        check("tmo_latency", done_cyc - acc_cyc, 20);
        drv_on = 1'b1;
        check("start_total", start_cnt, 10);
`else
        check("start_total", start_cnt, 9);
`endif
        repeat (3) @(negedge clk_i);
        check("cmd_q_empty", exp_cmd.size(), 0);
        check("done_q_empty", exp_done.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iic_arbiter.md
IIC_ARBITER -- requirements
Module: iic_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 50000, clk_i cycles allowed per transaction before abort (used only with IIC_ARB_TIMEOUT_EN).
REQ-002 clk_i  input  1  single clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  2  per-requester transaction request; bit i belongs to requester i.
REQ-005 req_rd  input  2  per-requester direction: 0 write, 1 read.
REQ-006 req_dev  input  16  device address; requester i on bits [8i+7:8i].
REQ-007 req_reg  input  32  register address; requester i on bits [16i+15:16i].
REQ-008 req_wdata  input  16  write byte; requester i on bits [8i+7:8i].
REQ-009 req_ready  output  2  command accepted from requester i when req_valid[i] & req_ready[i].
REQ-010 req_done  output  2  one-cycle completion pulse to requester i.
REQ-011 req_err  output  2  error status for requester i, valid only while req_done[i]=1.
REQ-012 rdata  output  8  read byte, valid while any req_done bit is 1.
REQ-013 grant  output  1  index of the current or last owner.
REQ-014 start_en  output  1  one-cycle start pulse to the IIC driver.
REQ-015 wr_rd_flag  output  1  driver direction: 0 write, 1 read.
REQ-016 i2c_device_addr  output  8  driver device address.
REQ-017 register  output  16  driver register address.
REQ-018 data_byte  output  8  driver write byte.
REQ-019 busy  input  1  driver busy.
REQ-020 err  input  1  driver error (may pulse).
REQ-021 rd_data  input  8  driver read byte.

Function
REQ-022 FSM states: IDLE, START, WAIT_BUSY, RUN, DONE.
REQ-023 IDLE, arbitration:
  - when req_valid is nonzero, req_ready is asserted combinationally for exactly one requester, chosen round-robin;
  - req_ready is 0 in all other states.
REQ-024 Round-robin rule: if both requesters are valid, the one not equal to last_grant wins; if only one is valid, it wins regardless of last_grant.
REQ-025 On accept (IDLE with a valid&ready handshake):
  - latch req_rd/req_dev/req_reg/req_wdata of the winner into wr_rd_flag/i2c_device_addr/register/data_byte;
  - set grant to the winner;
  - next state START.
REQ-026 The latched driver-side outputs hold stable from accept until leaving DONE.
REQ-027 START: start_en=1 for exactly one cycle (the cycle after accept); next state WAIT_BUSY.
REQ-028 WAIT_BUSY: remain until busy=1, then go to RUN.
REQ-029 RUN:
  - err_acc <= err_acc | err every cycle;
  - on busy=0, capture rd_data into rdata and go to DONE;
  - err asserted in the same cycle busy falls is included.
REQ-030 DONE, for one cycle:
  - req_done[grant]=1;
  - req_err[grant]=err_acc;
  - last_grant <= grant;
  - clear err_acc;
  - next state IDLE.
REQ-031 Back-to-back: a request pending on entry to IDLE is accepted that same cycle; minimum spacing between start_en pulses is therefore 4 cycles plus the driver busy time.
REQ-032 A requester that drops req_valid before being accepted is not serviced; req_valid changes after accept have no effect.
REQ-033 start_en is never asserted while busy=1 is observed in IDLE; IDLE waits for busy=0 before asserting any req_ready.

Reset
REQ-034 rst_n=0 sampled on a rising edge forces, on that edge:
  - state IDLE;
  - start_en, req_done, req_err, req_ready, rdata, grant, wr_rd_flag, i2c_device_addr, register, data_byte and err_acc to 0;
  - last_grant to 1, so requester 0 has first priority.
REQ-035 Reset mid-transaction abandons the transaction without a req_done pulse; the driver is not otherwise signalled.

Configuration
REQ-036 Macro IIC_ARB_TIMEOUT_EN defined:
  - a 16-bit counter clears on accept and increments in WAIT_BUSY and RUN;
  - on reaching TIMEOUT_CYCLES, go to DONE with req_err[grant]=1 and rdata=0.
REQ-037 IIC_ARB_TIMEOUT_EN undefined: no counter is present, and WAIT_BUSY/RUN wait indefinitely.

Verification
REQ-038 Single write: req_valid=01, rd=0, dev=0x78, reg=0x3008, wdata=0x82; driver busy for 100 cycles -> start_en pulses once with those values, then req_done=01 and req_err=00.
REQ-039 Contention: req_valid=11 held after reset -> grant order 0,1,0,1, with exactly one start_en per transaction.
REQ-040 Read: requester 1, rd=1, driver returns rd_data=0xA5 with an err pulse mid-RUN -> req_done=10, req_err=10, rdata=0xA5.
REQ-041 rst_n low for 1 cycle during RUN -> no req_done pulse, all outputs 0 next cycle, and a subsequent request completes normally.
REQ-042 With IIC_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=20, driver never asserts busy -> req_done and req_err for the owner 20 cycles after accept.
